// File: rtl/pipe_pkg.sv
// Shared constants and skid-buffer occupancy encoding for pipe_stage.
package pipe_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_CTRL_W = 8;
    localparam int DEF_CNT_W  = 16;

    // Side-effect control bits carried across each CPU pipeline boundary
    localparam int IF_ID_CTRL_W  = 1;
    localparam int ID_EX_CTRL_W  = 8;
    localparam int EX_MEM_CTRL_W = 4;
    localparam int MEM_WB_CTRL_W = 2;

    typedef logic [1:0] skid_state_t;

    localparam skid_state_t SKID_EMPTY = 2'd0;
    localparam skid_state_t SKID_ONE   = 2'd1;
    localparam skid_state_t SKID_FULL  = 2'd2;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry occupancy tracker for pipe_stage: owns the skid register and
// produces a registered-only in_ready so out_ready never reaches upstream.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             main_valid,
    output logic             skid_valid,
    output logic [WIDTH-1:0] skid_data
);

    skid_state_t state;
    skid_state_t state_next;
    logic        take;

    assign skid_valid = (state == SKID_FULL);
    assign main_valid = (state != SKID_EMPTY);
    assign in_ready   = !flush && !skid_valid;
    assign take       = in_valid && in_ready;

    always_comb begin
        state_next = state;
        case (state)
            SKID_EMPTY: if (take) state_next = SKID_ONE;
            SKID_ONE: begin
                if (take && !out_ready)
                    state_next = SKID_FULL;
                else if (!take && out_ready)
                    state_next = SKID_EMPTY;
            end
            SKID_FULL:  if (out_ready) state_next = SKID_ONE;
            default:    state_next = SKID_EMPTY;
        endcase
        if (flush)
            state_next = SKID_EMPTY;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= SKID_EMPTY;
        else
            state <= state_next;
    end

    // A payload parks here only when the main register is busy and stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            skid_data <= '0;
        else if (flush)
            skid_data <= '0;
        else if (state == SKID_ONE && take && !out_ready)
            skid_data <= in_data;
    end

endmodule

// File: rtl/pipe_stage.sv
// Flushable valid/ready pipeline stage with a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to build the 2-entry skid buffer with registered in_ready.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [WIDTH-1:0] CTRL_MASK = ~({WIDTH{1'b1}} << CTRL_W);

    logic             take;
    logic             give;
    logic             refill;
    logic [WIDTH-1:0] refill_data;

`ifdef PIPE_STAGE_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    pipe_skid_buf #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .main_valid(out_valid),
        .skid_valid(skid_valid),
        .skid_data (skid_data)
    );

    assign refill      = skid_valid && out_ready;
    assign refill_data = skid_data;
`else
    logic valid_q;

    assign in_ready    = !flush && (!valid_q || out_ready);
    assign out_valid   = valid_q;
    assign refill      = 1'b0;
    assign refill_data = '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            valid_q <= 1'b0;
        else if (flush)
            valid_q <= 1'b0;
        else if (take)
            valid_q <= 1'b1;
        else if (give)
            valid_q <= 1'b0;
    end
`endif

    assign take = in_valid && in_ready;
    assign give = out_valid && out_ready;

    // Draining keeps the upper bits but must leave a bubble with no side effects
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            out_data <= '0;
        else if (flush)
            out_data <= '0;
        else if (refill)
            out_data <= refill_data;
        else if (take && (!out_valid || out_ready))
            out_data <= in_data;
        else if (give)
            out_data <= out_data & ~CTRL_MASK;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: queue-based reference model plus directed literals.
// Follows PIPE_STAGE_SKID_EN to size the model's capacity and upstream behaviour.
module tb_pipe_stage;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b1;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [31:0] in_data   = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  stall_cnt;

    int total = 0;
    int bad   = 0;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    pipe_stage #(
        .WIDTH (32),
        .CTRL_W(8),
        .CNT_W (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference: the stage is a FIFO of capacity 1 (or 2 with skid) in front of downstream
    logic [31:0] mq[$];
    int          m_cnt  = 0;
    bit          m_zero = 1'b1;

    function automatic bit modelInReady();
        if (flush)
            return 1'b0;
        if (SKID)
            return mq.size() < 2;
        return mq.size() == 0 || out_ready;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        bit acc;
        if (!reset_n) begin
            mq.delete();
            m_cnt  = 0;
            m_zero = 1'b1;
        end else begin
            acc = in_valid && modelInReady();
            if (mq.size() > 0 && !out_ready && m_cnt < 15)
                m_cnt++;
            if (flush) begin
                mq.delete();
                m_zero = 1'b1;
            end else begin
                if (mq.size() > 0 && out_ready)
                    void'(mq.pop_front());
                if (acc) begin
                    mq.push_back(in_data);
                    m_zero = 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("m_out_valid", 32'(out_valid), 32'(mq.size() > 0));
        checkOutput("m_in_ready", 32'(in_ready), 32'(modelInReady()));
        checkOutput("m_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        if (mq.size() > 0)
            checkOutput("m_out_data", out_data, mq[0]);
        else if (m_zero)
            checkOutput("m_bubble_zero", out_data, 32'h0);
        else
            checkOutput("m_bubble_ctrl", out_data & 32'hFF, 32'h0);
    end

    task automatic applyStimulus(input logic f, input logic v, input logic [31:0] d, input logic r);
        flush     = f;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_out_data", out_data, 32'h0);
        checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'h1);

        $display("[TB] single transfer");
        applyStimulus(1'b0, 1'b1, 32'h0000_0C0F, 1'b1);
        checkOutput("first_valid", 32'(out_valid), 32'h1);
        checkOutput("first_data", out_data, 32'h0000_0C0F);
        checkOutput("first_stall", 32'(stall_cnt), 32'h0);

        $display("[TB] back-to-back stream");
        applyStimulus(1'b0, 1'b1, 32'h10, 1'b1);
        checkOutput("stream_10", out_data, 32'h10);
        applyStimulus(1'b0, 1'b1, 32'h20, 1'b1);
        checkOutput("stream_20", out_data, 32'h20);
        applyStimulus(1'b0, 1'b1, 32'h30, 1'b1);
        checkOutput("stream_30", out_data, 32'h30);
        checkOutput("stream_valid", 32'(out_valid), 32'h1);

        $display("[TB] drain");
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("drain_valid", 32'(out_valid), 32'h0);
        checkOutput("drain_ctrl", out_data & 32'hFF, 32'h0);

        $display("[TB] stall with pending input");
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b0);
        checkOutput("stall_first", out_data, 32'h40);
        applyStimulus(1'b0, 1'b1, 32'h50, 1'b0);
        checkOutput("stall_in_ready", 32'(in_ready), 32'h0);
        applyStimulus(1'b0, !SKID, 32'h50, 1'b0);
        applyStimulus(1'b0, !SKID, 32'h50, 1'b0);
        checkOutput("stall_hold", out_data, 32'h40);
        checkOutput("stall_cnt3", 32'(stall_cnt), 32'h3);
        applyStimulus(1'b0, !SKID, 32'h50, 1'b1);
        checkOutput("release_50", out_data, 32'h50);
        checkOutput("release_valid", 32'(out_valid), 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("release_drain", 32'(out_valid), 32'h0);

        $display("[TB] flush while full");
        applyStimulus(1'b0, 1'b1, 32'hFF, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'hEE, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hDD;
        #1;
        checkOutput("flush_in_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("flush_valid", 32'(out_valid), 32'h0);
        checkOutput("flush_data", out_data, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("flush_nothing_left", 32'(out_valid), 32'h0);
        checkOutput("flush_keeps_cnt", 32'(stall_cnt), 32'h5);

        $display("[TB] counter saturation and async reset");
        applyStimulus(1'b0, 1'b1, 32'h77, 1'b0);
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("sat_cnt", 32'(stall_cnt), 32'hF);
        checkOutput("sat_hold", out_data, 32'h77);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("async_rst_cnt", 32'(stall_cnt), 32'h0);
        checkOutput("async_rst_valid", 32'(out_valid), 32'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("post_rst_valid", 32'(out_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
